// File: rtl/i2c_master_if.sv
// ============================================================================
// Module      : i2c_master_if
// Description : I2C pin bundle (push-pull SDA/SCL, 1 = released) plus busy LED.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface i2c_master_if;
    logic sda_pin;
    logic scl_pin;
    logic busy_led;

    modport master (output sda_pin, output scl_pin, output busy_led);
    modport slave  (input  sda_pin, input  scl_pin, input  busy_led);
endinterface

`default_nettype wire

// File: rtl/i2c_master_top.sv
// ============================================================================
// Module      : i2c_master_top
// Description : Autonomous, repeating single-byte I2C write master (iCE40 demo).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module i2c_master_top #(
    parameter int         CLK_DIV     = 30,
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter logic [7:0] DATA_BYTE   = 8'hA5,
    parameter int         START_DELAY = 8,
    parameter int         GAP_TICKS   = 40
) (
    input  wire logic   hwclk,
    input  wire logic   rst,
    i2c_master_if.master bus
);

    localparam int               c_cnt_w       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_div_max   = c_cnt_w'(CLK_DIV - 1);
    localparam logic [7:0]       c_addr_byte   = {SLAVE_ADDR, 1'b0};
    localparam logic [15:0]      c_start_delay = 16'(START_DELAY);
    localparam logic [15:0]      c_gap_ticks   = 16'(GAP_TICKS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_ACK1  = 3'd3,
        ST_DATA  = 3'd4,
        ST_ACK2  = 3'd5,
        ST_STOP  = 3'd6
    } state_t;

    logic [c_cnt_w-1:0] r_div;
    logic               w_tick;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_phase, w_phase_nxt;
    logic [2:0]  r_bit,   w_bit_nxt;
    logic [15:0] r_delay, w_delay_nxt;
    logic        w_scl_nxt, w_sda_nxt;

    assign w_tick = (r_div == c_div_max);

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Next position in the 80-tick transaction sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_delay_nxt = r_delay;
        if (r_state == ST_IDLE) begin
            if (r_delay <= 16'd1) begin
                w_state_nxt = ST_START;
                w_phase_nxt = 2'd0;
                w_bit_nxt   = 3'd0;
                w_delay_nxt = 16'd0;
            end else begin
                w_delay_nxt = r_delay - 16'd1;
            end
        end else if (r_phase != 2'd3) begin
            w_phase_nxt = r_phase + 2'd1;
        end else begin
            w_phase_nxt = 2'd0;
            case (r_state)
                ST_START: w_state_nxt = ST_ADDR;
                ST_ADDR: begin
                    if (r_bit == 3'd7) w_state_nxt = ST_ACK1;
                    w_bit_nxt = r_bit + 3'd1;
                end
                ST_ACK1:  w_state_nxt = ST_DATA;
                ST_DATA: begin
                    if (r_bit == 3'd7) w_state_nxt = ST_ACK2;
                    w_bit_nxt = r_bit + 3'd1;
                end
                ST_ACK2:  w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    w_delay_nxt = c_gap_ticks;
                end
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pin levels for the position being entered; ~bit selects MSB first.
    always_comb begin
        w_scl_nxt = 1'b1;
        w_sda_nxt = 1'b1;
        case (w_state_nxt)
            ST_START: begin
                w_scl_nxt = (w_phase_nxt != 2'd3);
                w_sda_nxt = ~w_phase_nxt[1];
            end
            ST_ADDR: begin
                w_scl_nxt = w_phase_nxt[1];
                w_sda_nxt = c_addr_byte[~w_bit_nxt];
            end
            ST_DATA: begin
                w_scl_nxt = w_phase_nxt[1];
                w_sda_nxt = DATA_BYTE[~w_bit_nxt];
            end
            ST_ACK1, ST_ACK2: begin
                w_scl_nxt = w_phase_nxt[1];
                w_sda_nxt = 1'b1;
            end
            ST_STOP: begin
                w_scl_nxt = (w_phase_nxt != 2'd0);
                w_sda_nxt = w_phase_nxt[1];
            end
            default: begin
                w_scl_nxt = 1'b1;
                w_sda_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_phase      <= 2'd0;
            r_bit        <= 3'd0;
            r_delay      <= c_start_delay;
            bus.scl_pin  <= 1'b1;
            bus.sda_pin  <= 1'b1;
            bus.busy_led <= 1'b0;
        end else if (w_tick) begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_bit        <= w_bit_nxt;
            r_delay      <= w_delay_nxt;
            bus.scl_pin  <= w_scl_nxt;
            bus.sda_pin  <= w_sda_nxt;
            bus.busy_led <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_top.sv
// ============================================================================
// Module      : tb_i2c_master_top
// Description : Scoreboard bench for i2c_master_top at CLK_DIV=2, default payload.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_master_top;

    localparam int CLK_DIV = 2;

    logic hwclk = 1'b0;
    logic rst   = 1'b1;

    i2c_master_if bus_if ();

    i2c_master_top #(
        .CLK_DIV     (CLK_DIV),
        .SLAVE_ADDR  (7'h50),
        .DATA_BYTE   (8'hA5),
        .START_DELAY (8),
        .GAP_TICKS   (40)
    ) dut (
        .hwclk (hwclk),
        .rst   (rst),
        .bus   (bus_if)
    );

    always #5 hwclk = ~hwclk;

    int cyc = 0;
    always @(posedge hwclk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    bit exp_bits[$];
    int exp_rise[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SDA at each SCL rising edge: 0xA0, ACK, 0xA5, ACK, then the STOP setup edge (SDA low).
    task automatic push_txn(input int nbits);
        logic [18:0] pattern;
        pattern = {8'hA0, 1'b1, 8'hA5, 1'b1, 1'b0};
        for (int i = 0; i < nbits; i++) exp_bits.push_back(pattern[18-i]);
    endtask

    // Monitor
    logic p_scl  = 1'b1;
    logic p_sda  = 1'b1;
    logic p_busy = 1'b0;
    bit   in_txn = 1'b0;
    int   busy_len   = 0;
    int   hi_changes = 0;

    always @(negedge hwclk) begin
        if (rst) begin
            in_txn = 1'b0;
        end else begin
            if (!p_busy && bus_if.busy_led) begin
                if (exp_rise.size() == 0) check("busy_rise_unexpected", cyc, 0);
                else check("busy_rise_cycle", cyc, exp_rise.pop_front());
                in_txn     = 1'b1;
                busy_len   = 0;
                hi_changes = 0;
            end
            if (in_txn) begin
                if (bus_if.busy_led) busy_len++;
                if (p_scl && bus_if.scl_pin && (p_sda != bus_if.sda_pin)) hi_changes++;
                if (!p_scl && bus_if.scl_pin) begin
                    if (exp_bits.size() == 0) check("scl_rise_unexpected", int'(bus_if.sda_pin), 2);
                    else check("sda_at_scl_rise", int'(bus_if.sda_pin), int'(exp_bits.pop_front()));
                end
                if (p_busy && !bus_if.busy_led) begin
                    check("busy_len_cycles", busy_len, 80 * CLK_DIV);
                    check("sda_change_scl_high", hi_changes, 2);
                    in_txn = 1'b0;
                end
            end
        end
        p_scl  = bus_if.scl_pin;
        p_sda  = bus_if.sda_pin;
        p_busy = bus_if.busy_led;
    end

    // Stimulus
    initial begin
        int r0;
        int r1;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge hwclk);
            check("reset_hold", int'({bus_if.sda_pin, bus_if.scl_pin, bus_if.busy_led}), 6);
        end

        @(negedge hwclk);
        rst = 1'b0;
        r0  = cyc;
        // Rise after 8 ticks, then 160 busy + 80 gap cycles per repetition.
        exp_rise.push_back(r0 + 16);
        exp_rise.push_back(r0 + 256);
        exp_rise.push_back(r0 + 496);
        push_txn(19);
        push_txn(19);
        push_txn(13);

        // Third transaction tick 54 is DATA bit 3, phase 2; reset lands one cycle later.
        repeat (605) @(posedge hwclk);
        #2 rst = 1'b1;
        #1 check("async_reset_mid_txn", int'({bus_if.sda_pin, bus_if.scl_pin, bus_if.busy_led}), 6);
        for (int i = 0; i < 3; i++) begin
            @(negedge hwclk);
            check("reset_mid_hold", int'({bus_if.sda_pin, bus_if.scl_pin, bus_if.busy_led}), 6);
        end

        @(negedge hwclk);
        rst = 1'b0;
        r1  = cyc;
        exp_rise.push_back(r1 + 16);
        push_txn(19);

        repeat (16 + 160 + 5) @(negedge hwclk);
        check("pending_bits", exp_bits.size(), 0);
        check("pending_rises", exp_rise.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/i2c_master_top.md
Name: i2c_master_top

Overview:
- FPGA top-level for the iCE40-HX8K breakout I2C demo.
- Autonomously and repeatedly performs a single-byte I2C write: START, address+W, ACK slot, data byte, ACK slot, STOP.
- Drives SDA and SCL as push-pull outputs, with logic 1 meaning released/high.
- Lights busy_led while a transaction is in progress.

Parameters:
- CLK_DIV, 30: hwclk cycles per quarter SCL bit-period ("tick"). 30 gives 100 kHz SCL at 12 MHz. Legal values ≥ 1.
- SLAVE_ADDR, 7'h50: 7-bit target address.
- DATA_BYTE, 8'hA5: byte written each transaction.
- START_DELAY, 8: ticks spent idle after reset before the first transaction.
- GAP_TICKS, 40: idle ticks between end of STOP and the next START.

Ports:
- hwclk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- sda_pin  output  1  I2C data line (1 = released/high).
- scl_pin  output  1  I2C clock line (1 = released/high).
- busy_led  output  1  high while a transaction is in progress (START through end of STOP).

Behaviour:
- Reset (async, active-high): scl_pin=1, sda_pin=1, busy_led=0, state=IDLE, tick divider=0, bit counter=0, delay counter=START_DELAY. Outputs must hold these values for the whole time rst is asserted.
- Tick generator: free-running counter 0..CLK_DIV-1. A one-cycle tick pulses when the counter wraps. All state/phase changes happen only on tick cycles.
- Each bit spans 4 ticks, phases 0-3:
  - Phase 0: SCL=0, SDA updated to the new bit.
  - Phase 1: SCL=0, SDA held.
  - Phases 2 and 3: SCL=1, SDA held.
  - Bits are sent MSB first. SDA never changes while SCL=1 except in START and STOP.
- IDLE (SCL=1, SDA=1, busy=0): decrement the delay counter each tick. At 0, go to START and set busy=1.
- START (4 ticks), phase sequence:
  - Phases 0 and 1: SDA=1, SCL=1.
  - Phase 2: SDA=0, SCL=1 (the START condition).
  - Phase 3: SDA=0, SCL=0.
- ADDR (8 bits): shifts {SLAVE_ADDR, 1'b0}; the R/W bit is 0 (write).
- ACK1 (1 bit): SDA=1 (released). The ACK is not sampled; a NACK is ignored and the sequence continues.
- DATA (8 bits): shifts DATA_BYTE.
- ACK2 (1 bit): same as ACK1.
- STOP (4 ticks), phase sequence:
  - Phase 0: SDA=0, SCL=0.
  - Phase 1: SDA=0, SCL=1.
  - Phase 2: SDA=1, SCL=1 (the STOP condition).
  - Phase 3: SDA=1, SCL=1.
  - At the end of phase 3: busy=0, load delay counter with GAP_TICKS, return to IDLE.
- Transaction length: exactly 80 ticks = 80*CLK_DIV hwclk cycles. Exactly 18 SCL high pulses (9 for ADDR+ACK1, 9 for DATA+ACK2).
- busy_led rises on the tick that enters START and falls on the tick leaving STOP.
- Outputs are registered; no combinational paths from inputs.
- Reset asserted mid-transaction: outputs immediately return to reset values (bus released, busy=0). After release, START_DELAY is counted again before a fresh transaction.
- The sequence repeats indefinitely. With CLK_DIV=1 a tick fires every cycle and behaviour is otherwise identical.

Test Plan:
- Reset hold: rst=1 for 10 cycles -> sda_pin=1, scl_pin=1, busy_led=0 throughout, including the cycle rst rises asynchronously mid-clock.
- First transaction timing: CLK_DIV=2, START_DELAY=8, release rst -> busy_led rises after 8 ticks (16 cycles), SDA falls while SCL=1, busy_led high for 160 cycles.
- Serial content: CLK_DIV=2, defaults -> SDA sampled on the 18 SCL rising edges = 1010000_0, 1, 10100101, 1 (0xA0, ack, 0xA5, ack).
- Bus legality: over full transactions, SDA changes while SCL=1 only twice per transaction (START falling, STOP rising).
- Repetition: GAP_TICKS=40, CLK_DIV=2 -> second START begins 80 cycles after first STOP completes; content identical.
- Mid-transaction reset: assert rst during DATA bit 3 -> sda_pin=scl_pin=1, busy_led=0 immediately; next START occurs START_DELAY ticks after release.
